// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed DIGITS-wide 7-segment display driver.
// Ports:
//   clk, rst_n      - clock (rising edge) and synchronous active-low reset
//   en              - scan enable; low blanks the display and freezes the scan
//   load            - capture value_in/dp_in into the pending shadow register
//   value_in, dp_in - digit nibbles (digit 0 = bits [3:0]) and decimal points
//   hex_mode        - show codes 10..15 as A b C d E F instead of blanking them
//   lz_blank        - blank leading zero digits (digit 0 is always shown)
//   seg, dp, an     - registered display pins, polarity set by parameters
//   digit_idx       - index of the digit currently driven
//   frame_done      - one-cycle pulse when the scan wraps back to digit 0
module seg7_scan_driver #(
    parameter int DIGITS = 4,
    parameter int REFRESH_DIV = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW = 1'b1,
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1,
    localparam int PW = $clog2(REFRESH_DIV)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  hex_mode,
    input  logic                  lz_blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic [IW-1:0]         digit_idx,
    output logic                  frame_done
);
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    logic [PW-1:0]         presc, nxt_presc;
    logic [IW-1:0]         nxt_idx;
    logic [4*DIGITS-1:0]   pend, disp, nxt_disp;
    logic [DIGITS-1:0]     pend_dp, disp_dp, nxt_dp, zero_above, sel;
    logic                  pend_valid, step, wrap, run, blank;
    logic [3:0]            nib;
    logic [6:0]            code;
    // Outputs are computed from the post-edge index and display contents so
    // that digit select and segment data always change on the same edge.
    always_comb begin
        zero_above = '0;
        run = 1'b1;
        step = en && presc == PW'(REFRESH_DIV - 1);
        wrap = step && digit_idx == IW'(DIGITS - 1);
        nxt_presc = !en ? presc : step ? '0 : presc + 1'b1;
        nxt_idx = !step ? digit_idx : wrap ? '0 : digit_idx + 1'b1;
        nxt_disp = (wrap && pend_valid) ? pend : disp;
        nxt_dp = (wrap && pend_valid) ? pend_dp : disp_dp;
        // zero_above[k]: nibble k and every higher nibble are zero
        for (int k = DIGITS - 1; k >= 0; k--) begin
            run = run && nxt_disp[4*k +: 4] == 4'd0;
            zero_above[k] = run;
        end
        nib = nxt_disp[4*nxt_idx +: 4];
        blank = lz_blank && nxt_idx != '0 && zero_above[nxt_idx];
        code = (blank || (!hex_mode && nib > 4'd9)) ? 7'h00 : SEG_LUT[nib];
        sel = DIGITS'(1) << nxt_idx;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc      <= '0;
            digit_idx  <= '0;
            frame_done <= 1'b0;
            pend       <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            disp       <= '0;
            disp_dp    <= '0;
            an         <= {DIGITS{AN_ACTIVE_LOW}};
            seg        <= {7{SEG_ACTIVE_LOW}};
            dp         <= SEG_ACTIVE_LOW;
        end else begin
            presc      <= nxt_presc;
            digit_idx  <= nxt_idx;
            frame_done <= wrap;
            disp       <= nxt_disp;
            disp_dp    <= nxt_dp;
            if (load) begin
                pend    <= value_in;
                pend_dp <= dp_in;
            end
            // a load on the wrap edge re-arms pending after the old data moves
            pend_valid <= load || (pend_valid && !wrap);
            an         <= {DIGITS{AN_ACTIVE_LOW}} ^ (en ? sel : '0);
            seg        <= {7{SEG_ACTIVE_LOW}} ^ (en ? code : 7'h00);
            dp         <= SEG_ACTIVE_LOW ^ (en && nxt_dp[nxt_idx]);
        end
    end
endmodule
